// File: rtl/register_file_param_pkg.sv
// Shared defaults and derived sizes for the parameterized register file.
package register_file_param_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    function automatic int rf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int rf_bytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/register_file_param_scoreboard.sv
// Per-register busy bits: RSV marks a pending write, WRITE retires it.
module reg_scoreboard
    import register_file_param_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rsv,
    input  logic [ADDR_WIDTH-1:0]          addr_rsv,
    input  logic                           write,
    input  logic [ADDR_WIDTH-1:0]          addr_w,
    output logic [rf_depth(ADDR_WIDTH)-1:0] busy,
    output logic [rf_depth(ADDR_WIDTH)-1:0] busy_nxt
);

    localparam int DEPTH = rf_depth(ADDR_WIDTH);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             rsv_ok;
    logic             clr_ok;

    always_comb begin
        rsv_ok = rsv && !(ZERO_REG && addr_rsv == '0);
        clr_ok = write && !(ZERO_REG && addr_w == '0);
        busy_d = busy_q;
        if (clr_ok) busy_d[addr_w] = 1'b0;
        // Set after clear so a same-cycle reservation survives its own retiring write.
        if (rsv_ok) busy_d[addr_rsv] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy     = busy_q;
    assign busy_nxt = busy_d;

endmodule

// File: rtl/register_file_param.sv
// Two-read/one-write register file with byte enables, optional zero register,
// optional write-to-read forwarding and a pending-write scoreboard.
module register_file_param
    import register_file_param_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      READ,
    input  logic [ADDR_WIDTH-1:0]     ADDR_R1,
    input  logic [ADDR_WIDTH-1:0]     ADDR_R2,
    output logic [DATA_WIDTH-1:0]     DATA_R1,
    output logic [DATA_WIDTH-1:0]     DATA_R2,
    output logic                      VALID_R,
    output logic                      BUSY_R1,
    output logic                      BUSY_R2,
    input  logic                      WRITE,
    input  logic [ADDR_WIDTH-1:0]     ADDR_W,
    input  logic [DATA_WIDTH-1:0]     DATA_W,
    input  logic [DATA_WIDTH/8-1:0]   BE_W,
    input  logic                      RSV,
    input  logic [ADDR_WIDTH-1:0]     ADDR_RSV
);

    localparam int DEPTH = rf_depth(ADDR_WIDTH);
    localparam int NB    = rf_bytes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] wr_merged;
    logic                  wr_en;

    logic [DATA_WIDTH-1:0] data_r1_q, data_r1_d;
    logic [DATA_WIDTH-1:0] data_r2_q, data_r2_d;
    logic                  busy_r1_q, busy_r1_d;
    logic                  busy_r2_q, busy_r2_d;
    logic                  valid_q,   valid_d;

    logic [DEPTH-1:0]      busy_cur;
    logic [DEPTH-1:0]      busy_nxt;

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk      (CLK),
        .rst_n    (RST),
        .rsv      (RSV),
        .addr_rsv (ADDR_RSV),
        .write    (WRITE),
        .addr_w   (ADDR_W),
        .busy     (busy_cur),
        .busy_nxt (busy_nxt)
    );

    always_comb begin
        wr_en     = WRITE && !(ZERO_REG && ADDR_W == '0);
        wr_merged = mem_q[ADDR_W];
        for (int k = 0; k < NB; k++) begin
            if (BE_W[k]) wr_merged[k*8 +: 8] = DATA_W[k*8 +: 8];
        end
        mem_d = mem_q;
        if (wr_en) mem_d[ADDR_W] = wr_merged;
    end

    // Forwarding reads the post-write image; otherwise the pre-edge contents.
    always_comb begin
        data_r1_d = data_r1_q;
        data_r2_d = data_r2_q;
        busy_r1_d = busy_r1_q;
        busy_r2_d = busy_r2_q;
        valid_d   = 1'b0;
        if (READ) begin
            valid_d = 1'b1;
            if (BYPASS) begin
                data_r1_d = mem_d[ADDR_R1];
                data_r2_d = mem_d[ADDR_R2];
                busy_r1_d = busy_nxt[ADDR_R1];
                busy_r2_d = busy_nxt[ADDR_R2];
            end else begin
                data_r1_d = mem_q[ADDR_R1];
                data_r2_d = mem_q[ADDR_R2];
                busy_r1_d = busy_cur[ADDR_R1];
                busy_r2_d = busy_cur[ADDR_R2];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            // Register i resets to its own index; index 0 is 0 either way.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_WIDTH'(i);
            data_r1_q <= '0;
            data_r2_q <= '0;
            busy_r1_q <= 1'b0;
            busy_r2_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            data_r1_q <= data_r1_d;
            data_r2_q <= data_r2_d;
            busy_r1_q <= busy_r1_d;
            busy_r2_q <= busy_r2_d;
            valid_q   <= valid_d;
        end
    end

    assign DATA_R1 = data_r1_q;
    assign DATA_R2 = data_r2_q;
    assign BUSY_R1 = busy_r1_q;
    assign BUSY_R2 = busy_r2_q;
    assign VALID_R = valid_q;

endmodule
